ps2_key_decoder: RTL and testbench

Receives the PS/2 keyboard serial stream, frames and checks each byte, and resolves the E0 (extended) and F0 (break) prefixes into complete key events. It also maintains a held-key bitmap for the 13 piano-control keys. It sits directly upstream of `unifiedInput`, which turns `key_held` into `UserInput` fields alongside the board buttons. It runs entirely on the system clock; `prog_clk` is not used.

---
 rtl/ps2_key_decoder_pkg.sv | 31 +++
 rtl/ps2_keymap.sv | 34 +++
 rtl/ps2_key_decoder.sv | 157 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and constants for the PS/2 key decoder: receiver states,
// key_held bit positions and the E0/F0 prefix bytes.
package ps2_key_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } Ps2State;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int KEY_COUNT = 13;

  localparam int KEY_A        = 0;
  localparam int KEY_S        = 1;
  localparam int KEY_D        = 2;
  localparam int KEY_F        = 3;
  localparam int KEY_G        = 4;
  localparam int KEY_H        = 5;
  localparam int KEY_J        = 6;
  localparam int KEY_UP       = 7;
  localparam int KEY_DOWN     = 8;
  localparam int KEY_LEFT     = 9;
  localparam int KEY_RIGHT    = 10;
  localparam int KEY_OCT_DOWN = 11;
  localparam int KEY_OCT_UP   = 12;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational lookup from (scan code, extended flag) to a key_held bit index.
// Kept apart from the receiver so the key layout can be edited on its own.
module ps2_keymap
  import ps2_key_decoder_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  output logic       o_hit,
  output logic [3:0] o_idx
);

  // The extended flag is part of the match key, so a plain 75 is not "up".
  always_comb begin
    o_hit = 1'b1;
    o_idx = 4'd0;
    case ({i_ext, i_code})
      9'h01C:  o_idx = 4'(KEY_A);
      9'h01B:  o_idx = 4'(KEY_S);
      9'h023:  o_idx = 4'(KEY_D);
      9'h02B:  o_idx = 4'(KEY_F);
      9'h034:  o_idx = 4'(KEY_G);
      9'h033:  o_idx = 4'(KEY_H);
      9'h03B:  o_idx = 4'(KEY_J);
      9'h175:  o_idx = 4'(KEY_UP);
      9'h172:  o_idx = 4'(KEY_DOWN);
      9'h16B:  o_idx = 4'(KEY_LEFT);
      9'h174:  o_idx = 4'(KEY_RIGHT);
      9'h01A:  o_idx = 4'(KEY_OCT_DOWN);
      9'h022:  o_idx = 4'(KEY_OCT_UP);
      default: o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames bytes, resolves E0/F0 prefixes into key events
// and tracks 13 held keys. Define PS2_TIMEOUT_EN to abandon stalled frames.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [7:0]           code,
  output logic                 code_ext,
  output logic                 code_break,
  output logic                 code_valid,
  output logic                 frame_err,
  output logic [KEY_COUNT-1:0] key_held
);

  logic [1:0]           r_clkSync;
  logic [1:0]           r_dataSync;
  logic                 r_clkHist;
  Ps2State              r_state;
  logic [2:0]           r_bitCnt;
  logic [7:0]           r_shift;
  logic                 r_parity;
  logic                 r_extPend;
  logic                 r_brkPend;
  logic [7:0]           r_code;
  logic                 r_codeExt;
  logic                 r_codeBreak;
  logic                 r_codeValid;
  logic                 r_frameErr;
  logic [KEY_COUNT-1:0] r_keyHeld;

  logic                 w_fall;
  logic                 w_bit;
  logic                 w_good;
  logic                 w_hit;
  logic [3:0]           w_idx;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_timer;
`endif

  // Synchronisers reset to the idle-high line level so no false edge appears.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkHist  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
      r_clkHist  <= r_clkSync[1];
    end
  end

  assign w_fall = r_clkHist & ~r_clkSync[1];
  assign w_bit  = r_dataSync[1];
  assign w_good = w_bit & (^{r_shift, r_parity});

  ps2_keymap u_keymap (
    .i_code (r_shift),
    .i_ext  (r_extPend),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_bitCnt    <= 3'd0;
      r_shift     <= 8'h00;
      r_parity    <= 1'b0;
      r_extPend   <= 1'b0;
      r_brkPend   <= 1'b0;
      r_code      <= 8'h00;
      r_codeExt   <= 1'b0;
      r_codeBreak <= 1'b0;
      r_codeValid <= 1'b0;
      r_frameErr  <= 1'b0;
      r_keyHeld   <= '0;
`ifdef PS2_TIMEOUT_EN
      r_timer     <= '0;
`endif
    end else begin
      r_codeValid <= 1'b0;
      r_frameErr  <= 1'b0;
      if (w_fall) begin
`ifdef PS2_TIMEOUT_EN
        r_timer <= '0;
`endif
        case (r_state)
          IDLE: begin
            if (!w_bit) begin
              r_state  <= DATA;
              r_bitCnt <= 3'd0;
            end
          end
          DATA: begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= w_bit;
            r_state  <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (!w_good) begin
              r_frameErr <= 1'b1;
              r_extPend  <= 1'b0;
              r_brkPend  <= 1'b0;
            end else if (r_shift == PS2_EXT) begin
              r_extPend <= 1'b1;
            end else if (r_shift == PS2_BRK) begin
              r_brkPend <= 1'b1;
            end else begin
              r_code      <= r_shift;
              r_codeExt   <= r_extPend;
              r_codeBreak <= r_brkPend;
              r_codeValid <= 1'b1;
              r_extPend   <= 1'b0;
              r_brkPend   <= 1'b0;
              if (w_hit) r_keyHeld[w_idx] <= ~r_brkPend;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
`ifdef PS2_TIMEOUT_EN
      else if (r_state != IDLE) begin
        if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          r_state    <= IDLE;
          r_timer    <= '0;
          r_extPend  <= 1'b0;
          r_brkPend  <= 1'b0;
          r_frameErr <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end
`endif
    end
  end

  assign code       = r_code;
  assign code_ext   = r_codeExt;
  assign code_break = r_codeBreak;
  assign code_valid = r_codeValid;
  assign frame_err  = r_frameErr;
  assign key_held   = r_keyHeld;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus randomized
// key events checked against a byte-level behavioural model.
module tb_ps2_key_decoder;

`ifdef PS2_TIMEOUT_EN
  localparam int TO = 1000;
`else
  localparam int TO = 200000;
`endif

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [7:0]  code;
  logic        code_ext;
  logic        code_break;
  logic        code_valid;
  logic        frame_err;
  logic [12:0] key_held;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_ext   (code_ext),
    .code_break (code_break),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .key_held   (key_held)
  );

  int nTests = 0;
  int nFail  = 0;

  // Pulse monitor: counts events and records what the outputs showed during them.
  int          nValid = 0;
  int          nErr = 0;
  int          nLong = 0;
  int          nBoth = 0;
  logic [7:0]  lastCode = 8'h00;
  logic        lastExt = 1'b0;
  logic        lastBrk = 1'b0;
  logic [12:0] heldAtValid = '0;
  logic        prevV = 1'b0;
  logic        prevE = 1'b0;

  always @(negedge clk) begin
    if (code_valid) begin
      nValid++;
      lastCode    = code;
      lastExt     = code_ext;
      lastBrk     = code_break;
      heldAtValid = key_held;
      if (prevV) nLong++;
    end
    if (frame_err) begin
      nErr++;
      if (prevE) nLong++;
    end
    if (code_valid && frame_err) nBoth++;
    prevV = code_valid;
    prevE = frame_err;
  end

  // Reference model: the 13-key table in bit order as {extended, code}.
  logic [8:0]  keyTab [13] = '{9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034, 9'h033, 9'h03B,
                                9'h175, 9'h172, 9'h16B, 9'h174, 9'h01A, 9'h022};
  int          expValid = 0;
  int          expErr = 0;
  logic        mExt = 1'b0;
  logic        mBrk = 1'b0;
  logic [12:0] mHeld = '0;

  task automatic modelByte(input logic [7:0] b, input bit good);
    if (!good) begin
      expErr++;
      mExt = 1'b0;
      mBrk = 1'b0;
    end else if (b == 8'hE0) begin
      mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      expValid++;
      for (int i = 0; i < 13; i++)
        if (keyTab[i] == {mExt, b}) mHeld[i] = ~mBrk;
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [10:0] bits, input int n, input int hp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] frameBits(input logic [7:0] b, input bit good);
    logic par;
    par = good ? ~^b : ^b;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic sendByte(input logic [7:0] b, input bit good);
    applyStimulus(frameBits(b, good), 11, 6);
    repeat (4) @(negedge clk);
    modelByte(b, good);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nTests++; if (code !== 8'h00)      begin nFail++; $display("[TB] FAIL reset_code: got %h want 00", code); end
    nTests++; if (code_ext !== 1'b0)   begin nFail++; $display("[TB] FAIL reset_ext: got %b want 0", code_ext); end
    nTests++; if (code_break !== 1'b0) begin nFail++; $display("[TB] FAIL reset_brk: got %b want 0", code_break); end
    nTests++; if (code_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %b want 0", code_valid); end
    nTests++; if (frame_err !== 1'b0)  begin nFail++; $display("[TB] FAIL reset_err: got %b want 0", frame_err); end
    nTests++; if (key_held !== 13'h0)  begin nFail++; $display("[TB] FAIL reset_held: got %h want 0", key_held); end
    sys_rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_make();
    sendByte(8'h1C, 1'b1);
    nTests++; if (nValid !== 1)          begin nFail++; $display("[TB] FAIL make_count: got %0d want 1", nValid); end
    nTests++; if (lastCode !== 8'h1C)    begin nFail++; $display("[TB] FAIL make_code: got %h want 1C", lastCode); end
    nTests++; if ({lastExt, lastBrk} !== 2'b00) begin nFail++; $display("[TB] FAIL make_flags: got %b want 00", {lastExt, lastBrk}); end
    nTests++; if (key_held !== 13'h0001) begin nFail++; $display("[TB] FAIL make_held: got %h want 0001", key_held); end
  endtask

  task automatic test_break();
    sendByte(8'hF0, 1'b1);
    nTests++; if (nValid !== 1) begin nFail++; $display("[TB] FAIL break_prefix_silent: got %0d want 1", nValid); end
    sendByte(8'h1C, 1'b1);
    nTests++; if (nValid !== 2)         begin nFail++; $display("[TB] FAIL break_count: got %0d want 2", nValid); end
    nTests++; if ({lastExt, lastBrk} !== 2'b01) begin nFail++; $display("[TB] FAIL break_flags: got %b want 01", {lastExt, lastBrk}); end
    nTests++; if (key_held !== 13'h0)   begin nFail++; $display("[TB] FAIL break_held: got %h want 0", key_held); end
  endtask

  task automatic test_extended();
    sendByte(8'hE0, 1'b1);
    sendByte(8'h75, 1'b1);
    nTests++; if (key_held !== 13'h0080) begin nFail++; $display("[TB] FAIL ext_make_held: got %h want 0080", key_held); end
    nTests++; if ({lastExt, lastBrk} !== 2'b10) begin nFail++; $display("[TB] FAIL ext_make_flags: got %b want 10", {lastExt, lastBrk}); end
    sendByte(8'hE0, 1'b1);
    sendByte(8'hF0, 1'b1);
    sendByte(8'h75, 1'b1);
    nTests++; if (key_held !== 13'h0)   begin nFail++; $display("[TB] FAIL ext_break_held: got %h want 0", key_held); end
    nTests++; if ({lastExt, lastBrk} !== 2'b11) begin nFail++; $display("[TB] FAIL ext_break_flags: got %b want 11", {lastExt, lastBrk}); end
    sendByte(8'h75, 1'b1);
    nTests++; if (key_held !== 13'h0)   begin nFail++; $display("[TB] FAIL plain75_held: got %h want 0", key_held); end
    nTests++; if (nValid !== 5)         begin nFail++; $display("[TB] FAIL ext_count: got %0d want 5", nValid); end
  endtask

  task automatic test_parity_err();
    sendByte(8'h1C, 1'b0);
    nTests++; if (nErr !== 1)          begin nFail++; $display("[TB] FAIL parity_err_count: got %0d want 1", nErr); end
    nTests++; if (nValid !== 5)        begin nFail++; $display("[TB] FAIL parity_no_valid: got %0d want 5", nValid); end
    nTests++; if (key_held !== 13'h0)  begin nFail++; $display("[TB] FAIL parity_held: got %h want 0", key_held); end
    nTests++; if (code !== 8'h75)      begin nFail++; $display("[TB] FAIL parity_code_hold: got %h want 75", code); end
    sendByte(8'h1C, 1'b1);
    sendByte(8'hF0, 1'b1);
    sendByte(8'h1C, 1'b1);
    nTests++; if ({lastCode, lastBrk} !== {8'h1C, 1'b1}) begin nFail++; $display("[TB] FAIL parity_recover: got %h/%b want 1C/1", lastCode, lastBrk); end
    nTests++; if (key_held !== 13'h0)  begin nFail++; $display("[TB] FAIL parity_recover_held: got %h want 0", key_held); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(frameBits(8'h1B, 1'b1), 11, 3);
    applyStimulus(frameBits(8'h23, 1'b1), 11, 3);
    repeat (8) @(negedge clk);
    modelByte(8'h1B, 1'b1);
    modelByte(8'h23, 1'b1);
    nTests++; if (nValid !== expValid) begin nFail++; $display("[TB] FAIL b2b_count: got %0d want %0d", nValid, expValid); end
    nTests++; if (lastCode !== 8'h23)  begin nFail++; $display("[TB] FAIL b2b_code: got %h want 23", lastCode); end
    nTests++; if (key_held !== 13'h0006) begin nFail++; $display("[TB] FAIL b2b_held: got %h want 0006", key_held); end
  endtask

  task automatic test_random();
    logic [8:0] ent;
    logic [7:0] c;
    logic       e, b;
    bit         bad;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        ent = keyTab[$urandom_range(0, 12)];
        c = ent[7:0];
        e = ent[8];
      end else begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'hE0 || c == 8'hF0) c = 8'h75;
        e = 1'($urandom_range(0, 1));
      end
      b = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 9) == 0);
      if (e) sendByte(8'hE0, 1'b1);
      if (b) sendByte(8'hF0, 1'b1);
      sendByte(c, !bad);
      nTests++; if (nValid !== expValid) begin nFail++; $display("[TB] FAIL rand_valid_count: got %0d want %0d", nValid, expValid); end
      nTests++; if (nErr !== expErr)     begin nFail++; $display("[TB] FAIL rand_err_count: got %0d want %0d", nErr, expErr); end
      nTests++; if (key_held !== mHeld)  begin nFail++; $display("[TB] FAIL rand_held: got %h want %h", key_held, mHeld); end
      if (!bad) begin
        nTests++; if ({lastExt, lastBrk, lastCode} !== {e, b, c}) begin nFail++; $display("[TB] FAIL rand_event: got %b%b/%h want %b%b/%h", lastExt, lastBrk, lastCode, e, b, c); end
        nTests++; if (heldAtValid !== mHeld) begin nFail++; $display("[TB] FAIL rand_held_timing: got %h want %h", heldAtValid, mHeld); end
      end
    end
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout();
    int startErr;
    int waited;
    startErr = nErr;
    waited = 0;
    applyStimulus(11'b000_0000_0100, 4, 6);
    ps2_data = 1'b1;
    while (nErr == startErr && waited < 1500) begin
      @(negedge clk);
      waited++;
    end
    expErr++;
    mExt = 1'b0;
    mBrk = 1'b0;
    nTests++; if (nErr !== expErr) begin nFail++; $display("[TB] FAIL timeout_err: got %0d want %0d", nErr, expErr); end
    nTests++; if (waited < 985 || waited > 1005) begin nFail++; $display("[TB] FAIL timeout_delay: got %0d want ~996", waited); end
    sendByte(8'h22, 1'b1);
    nTests++; if (key_held !== mHeld || !key_held[12]) begin nFail++; $display("[TB] FAIL timeout_recover: got %h want %h", key_held, mHeld); end
  endtask
`endif

  task automatic test_reset_midframe();
    sendByte(8'h1C, 1'b1);
    applyStimulus(frameBits(8'h5A, 1'b1), 5, 6);
    @(negedge clk);
    #2 sys_rst_n = 1'b0;
    #1;
    nTests++; if (key_held !== 13'h0) begin nFail++; $display("[TB] FAIL rst_mid_held: got %h want 0", key_held); end
    nTests++; if ({code, code_ext, code_break, code_valid, frame_err} !== 12'h0) begin nFail++; $display("[TB] FAIL rst_mid_outputs: got %h want 0", {code, code_ext, code_break, code_valid, frame_err}); end
    mHeld = '0;
    mExt = 1'b0;
    mBrk = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sendByte(8'h1A, 1'b1);
    nTests++; if (key_held !== 13'h0800) begin nFail++; $display("[TB] FAIL rst_mid_resume: got %h want 0800", key_held); end
    nTests++; if (code !== 8'h1A)        begin nFail++; $display("[TB] FAIL rst_mid_code: got %h want 1A", code); end
  endtask

  task automatic test_pulse_width();
    nTests++; if (nLong !== 0) begin nFail++; $display("[TB] FAIL pulse_width: got %0d long pulses want 0", nLong); end
    nTests++; if (nBoth !== 0) begin nFail++; $display("[TB] FAIL pulse_overlap: got %0d want 0", nBoth); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity_err();
    test_back_to_back();
    test_random();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midframe();
    test_pulse_width();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
